// File: rtl/fifo_skip_ctrl.sv
// fifo_skip_ctrl: single-clock stream FIFO with a multi-entry skip on read.
// The skip is clamped to the current occupancy, so the read pointer cannot
// pass the write pointer. Status flags are registered from the next-state
// occupancy, so they are exact on the cycle after each operation.
//
// Request/accept semantics: wr_i and rd_i are requests sampled on every rising
// edge of clk_i. There is no separate ready signal; full_o and empty_o act as
// the ready indications. A write is accepted only when full_o=0, and a read only
// when empty_o=0. A request made while the FIFO is not ready is dropped with no
// state change and is reported one cycle later on overflow_o or underflow_o.
module fifo_skip_ctrl #(
  parameter int DWIDTH       = 8,
  parameter int AWIDTH       = 4,
  parameter int SWIDTH       = 2,
  parameter int SHOWAHEAD    = 0,
  parameter int ALMOST_FULL  = 12,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              wr_i,
  input  logic [DWIDTH-1:0] wrdata_i,
  input  logic              rd_i,
  input  logic [SWIDTH-1:0] shift_i,
  output logic [DWIDTH-1:0] rddata_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_empty_o,
  output logic              almost_full_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int DEPTH = 1 << AWIDTH;

  // Occupancy-domain constants, all AWIDTH+1 bits wide.
  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] AF_TH   = (AWIDTH+1)'(ALMOST_FULL);
  localparam logic [AWIDTH:0] AE_TH   = (AWIDTH+1)'(ALMOST_EMPTY);
  localparam logic [AWIDTH:0] ONE_W   = (AWIDTH+1)'(1);

  // Storage; intentionally not reset so it maps onto block RAM.
  logic [DWIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AWIDTH:0] wrptr;
  logic [AWIDTH:0] rdptr;

  logic            wr_acc;
  logic            rd_acc;
  logic [AWIDTH:0] shift_ext;
  logic [AWIDTH:0] shift_eff;
  logic [AWIDTH:0] rd_cnt;
  logic [AWIDTH:0] rd_sub;
  logic [AWIDTH:0] usedw_next;

  // Accept decisions and skip amount: a shift of 0 means one entry, and the
  // skip never exceeds what is currently stored.
  always_comb begin
    wr_acc    = wr_i & ~full_o;
    rd_acc    = rd_i & ~empty_o;
    shift_ext = (AWIDTH+1)'(shift_i);
    shift_eff = (shift_ext == '0) ? ONE_W : shift_ext;
    rd_cnt    = (shift_eff > usedw_o) ? usedw_o : shift_eff;
    rd_sub    = rd_acc ? rd_cnt : '0;
  end

  // Next occupancy; a simultaneous accepted write and read nets to 1 - rd_cnt.
  always_comb begin
    usedw_next = usedw_o + (AWIDTH+1)'(wr_acc) - rd_sub;
  end

  // Memory write port; a write in a reset cycle is ignored along with the rest.
  always_ff @(posedge clk_i) begin
    if (wr_acc && !srst_i) begin
      mem[wrptr[AWIDTH-1:0]] <= wrdata_i;
    end
  end

  // Pointer update; both pointers wrap modulo 2**(AWIDTH+1).
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wrptr <= '0;
      rdptr <= '0;
    end else begin
      if (wr_acc) begin
        wrptr <= wrptr + ONE_W;
      end
      if (rd_acc) begin
        rdptr <= rdptr + rd_cnt;
      end
    end
  end

  // Occupancy and status flags, all registered from the next-state count.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      usedw_o        <= '0;
      empty_o        <= 1'b1;
      full_o         <= 1'b0;
      almost_empty_o <= 1'b1;
      almost_full_o  <= 1'b0;
    end else begin
      usedw_o        <= usedw_next;
      empty_o        <= (usedw_next == '0);
      full_o         <= (usedw_next == DEPTH_W);
      almost_empty_o <= (usedw_next <= AE_TH);
      almost_full_o  <= (usedw_next >= AF_TH);
    end
  end

  // Error strobes: one-cycle pulse after a request the FIFO could not take.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      overflow_o  <= wr_i & full_o;
      underflow_o <= rd_i & empty_o;
    end
  end

  generate
    if (SHOWAHEAD != 0) begin : g_showahead
      // Head word presented combinationally; meaningless while empty.
      always_comb begin
        rddata_o = mem[rdptr[AWIDTH-1:0]];
      end
    end else begin : g_registered
      // Registered read of the old head on an accepted read; holds otherwise.
      always_ff @(posedge clk_i) begin
        if (srst_i) begin
          rddata_o <= '0;
        end else if (rd_acc) begin
          rddata_o <= mem[rdptr[AWIDTH-1:0]];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fifo_skip_ctrl.sv
// Directed bench for fifo_skip_ctrl with default parameters (16 x 8 bits,
// ALMOST_FULL=12, ALMOST_EMPTY=2, registered read).
module tb_fifo_skip_ctrl;

  logic       clk;
  logic       srst;
  logic       wr;
  logic [7:0] wrdata;
  logic       rd;
  logic [1:0] shift;
  logic [7:0] rddata;
  logic [4:0] usedw;
  logic       empty;
  logic       full;
  logic       almost_empty;
  logic       almost_full;
  logic       overflow;
  logic       underflow;

  int n_vec;
  int n_err;

  // scoreboard of words the FIFO should currently hold, head at index 0
  logic [7:0] exp_q[$];
  logic [7:0] exp_rd;

  fifo_skip_ctrl #(
    .DWIDTH(8), .AWIDTH(4), .SWIDTH(2), .SHOWAHEAD(0),
    .ALMOST_FULL(12), .ALMOST_EMPTY(2)
  ) dut (
    .clk_i(clk),
    .srst_i(srst),
    .wr_i(wr),
    .wrdata_i(wrdata),
    .rd_i(rd),
    .shift_i(shift),
    .rddata_o(rddata),
    .usedw_o(usedw),
    .empty_o(empty),
    .full_o(full),
    .almost_empty_o(almost_empty),
    .almost_full_o(almost_full),
    .overflow_o(overflow),
    .underflow_o(underflow)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drive one cycle of requests; outputs are settled on return
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic [1:0] s);
    wr = w; wrdata = d; rd = r; shift = s;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0; shift = 2'd0;
  endtask

  // synchronous reset with wr/rd also raised to show they are ignored
  task automatic do_reset(input logic w, input logic r);
    srst = 1'b1; wr = w; wrdata = 8'hEE; rd = r; shift = 2'd1;
    @(posedge clk); #1;
    srst = 1'b0; wr = 1'b0; rd = 1'b0; shift = 2'd0;
    exp_q.delete();
    exp_rd = 8'h00;
  endtask

  task automatic test_reset();
    srst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    srst = 1'b0;
    exp_q.delete();
    exp_rd = 8'h00;
    n_vec++; if (usedw !== 5'd0)     begin n_err++; $display("FAIL reset_usedw got %0d want 0", usedw); end
    n_vec++; if (empty !== 1'b1)     begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
    n_vec++; if (full !== 1'b0)      begin n_err++; $display("FAIL reset_full got %b want 0", full); end
    n_vec++; if (almost_empty !== 1'b1) begin n_err++; $display("FAIL reset_ae got %b want 1", almost_empty); end
    n_vec++; if (almost_full !== 1'b0)  begin n_err++; $display("FAIL reset_af got %b want 0", almost_full); end
    n_vec++; if ({overflow, underflow} !== 2'b00) begin n_err++; $display("FAIL reset_strobes got %b%b want 00", overflow, underflow); end
    n_vec++; if (rddata !== 8'h00)   begin n_err++; $display("FAIL reset_rddata got %h want 00", rddata); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 2'd0);
      n_vec++; if (usedw !== 5'(i + 1)) begin n_err++; $display("FAIL fill_usedw[%0d] got %0d want %0d", i, usedw, i + 1); end
      n_vec++; if (almost_full !== (i + 1 >= 12)) begin n_err++; $display("FAIL fill_af[%0d] got %b want %b", i, almost_full, (i + 1 >= 12)); end
      n_vec++; if (almost_empty !== (i + 1 <= 2)) begin n_err++; $display("FAIL fill_ae[%0d] got %b want %b", i, almost_empty, (i + 1 <= 2)); end
      n_vec++; if (full !== (i == 15)) begin n_err++; $display("FAIL fill_full[%0d] got %b want %b", i, full, (i == 15)); end
      n_vec++; if (empty !== 1'b0) begin n_err++; $display("FAIL fill_empty[%0d] got %b want 0", i, empty); end
    end
  endtask

  task automatic test_overflow_drain();
    step(1'b1, 8'hAA, 1'b0, 2'd0);
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_pulse got %b want 1", overflow); end
    n_vec++; if (usedw !== 5'd16)   begin n_err++; $display("FAIL ovf_usedw got %0d want 16", usedw); end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 2'd1);
      if (i == 0) begin
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", overflow); end
      end
      n_vec++; if (rddata !== 8'(i)) begin n_err++; $display("FAIL drain_data[%0d] got %h want %h", i, rddata, 8'(i)); end
      n_vec++; if (usedw !== 5'(15 - i)) begin n_err++; $display("FAIL drain_usedw[%0d] got %0d want %0d", i, usedw, 15 - i); end
    end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL drain_empty got %b want 1", empty); end
    n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL drain_unf got %b want 0", underflow); end
  endtask

  task automatic test_skip();
    for (int i = 0; i < 6; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 2'd0);
    n_vec++; if (usedw !== 5'd6) begin n_err++; $display("FAIL skip_fill got %0d want 6", usedw); end
    step(1'b0, 8'h00, 1'b1, 2'd3);
    n_vec++; if (rddata !== 8'h10) begin n_err++; $display("FAIL skip_data got %h want 10", rddata); end
    n_vec++; if (usedw !== 5'd3)   begin n_err++; $display("FAIL skip_usedw got %0d want 3", usedw); end
    step(1'b0, 8'h00, 1'b1, 2'd1);
    n_vec++; if (rddata !== 8'h13) begin n_err++; $display("FAIL skip_next got %h want 13", rddata); end
    n_vec++; if (usedw !== 5'd2)   begin n_err++; $display("FAIL skip_usedw2 got %0d want 2", usedw); end
  endtask

  task automatic test_clamp();
    // holds 0x14, 0x15
    step(1'b0, 8'h00, 1'b1, 2'd3);
    n_vec++; if (rddata !== 8'h14)   begin n_err++; $display("FAIL clamp_data got %h want 14", rddata); end
    n_vec++; if (usedw !== 5'd0)     begin n_err++; $display("FAIL clamp_usedw got %0d want 0", usedw); end
    n_vec++; if (empty !== 1'b1)     begin n_err++; $display("FAIL clamp_empty got %b want 1", empty); end
    n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL clamp_nounf got %b want 0", underflow); end
    step(1'b0, 8'h00, 1'b1, 2'd1);
    n_vec++; if (underflow !== 1'b1) begin n_err++; $display("FAIL unf_pulse got %b want 1", underflow); end
    n_vec++; if (rddata !== 8'h14)   begin n_err++; $display("FAIL unf_hold got %h want 14", rddata); end
    n_vec++; if (usedw !== 5'd0)     begin n_err++; $display("FAIL unf_usedw got %0d want 0", usedw); end
    step(1'b0, 8'h00, 1'b0, 2'd0);
    n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL unf_clear got %b want 0", underflow); end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 8'h20, 1'b0, 2'd0);
    step(1'b1, 8'h21, 1'b1, 2'd0);
    n_vec++; if (rddata !== 8'h20) begin n_err++; $display("FAIL b2b_data got %h want 20", rddata); end
    n_vec++; if (usedw !== 5'd1)   begin n_err++; $display("FAIL b2b_usedw got %0d want 1", usedw); end
    n_vec++; if (empty !== 1'b0)   begin n_err++; $display("FAIL b2b_empty got %b want 0", empty); end
    step(1'b0, 8'h00, 1'b1, 2'd2);
    n_vec++; if (rddata !== 8'h21) begin n_err++; $display("FAIL b2b_next got %h want 21", rddata); end
    n_vec++; if (empty !== 1'b1)   begin n_err++; $display("FAIL b2b_empty2 got %b want 1", empty); end
  endtask

  task automatic test_wrap();
    logic       w;
    logic       r;
    logic [1:0] s;
    logic [7:0] d;
    int         sz;
    int         cnt;
    logic       e_ovf;
    logic       e_unf;
    exp_q.delete();
    exp_rd = 8'h21;
    for (int c = 0; c < 100; c++) begin
      w  = ($urandom_range(0, 99) < 60);
      r  = ($urandom_range(0, 99) < 50);
      s  = 2'($urandom_range(0, 3));
      d  = 8'($urandom_range(0, 255));
      sz = exp_q.size();
      e_ovf = w && (sz == 16);
      e_unf = r && (sz == 0);
      if (r && sz > 0) begin
        cnt = (s == 2'd0) ? 1 : int'(s);
        if (cnt > sz) cnt = sz;
        exp_rd = exp_q[0];
        for (int k = 0; k < cnt; k++) void'(exp_q.pop_front());
      end
      if (w && sz < 16) exp_q.push_back(d);
      step(w, d, r, s);
      sz = exp_q.size();
      n_vec++; if (rddata !== exp_rd) begin n_err++; $display("FAIL wrap_data[%0d] got %h want %h", c, rddata, exp_rd); end
      n_vec++; if (usedw !== 5'(sz)) begin n_err++; $display("FAIL wrap_usedw[%0d] got %0d want %0d", c, usedw, sz); end
      n_vec++; if ({empty, full} !== {sz == 0, sz == 16}) begin n_err++; $display("FAIL wrap_ef[%0d] got %b%b want %b%b", c, empty, full, sz == 0, sz == 16); end
      n_vec++; if ({almost_empty, almost_full} !== {sz <= 2, sz >= 12}) begin n_err++; $display("FAIL wrap_almost[%0d] got %b%b want %b%b", c, almost_empty, almost_full, sz <= 2, sz >= 12); end
      n_vec++; if ({overflow, underflow} !== {e_ovf, e_unf}) begin n_err++; $display("FAIL wrap_strobe[%0d] got %b%b want %b%b", c, overflow, underflow, e_ovf, e_unf); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 2'd0);
    step(1'b1, 8'h45, 1'b1, 2'd1);
    do_reset(1'b1, 1'b1);
    n_vec++; if (usedw !== 5'd0)  begin n_err++; $display("FAIL mid_usedw got %0d want 0", usedw); end
    n_vec++; if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin n_err++; $display("FAIL mid_flags got %b want 1010", {empty, full, almost_empty, almost_full}); end
    n_vec++; if (rddata !== 8'h00) begin n_err++; $display("FAIL mid_rddata got %h want 00", rddata); end
    n_vec++; if ({overflow, underflow} !== 2'b00) begin n_err++; $display("FAIL mid_strobes got %b%b want 00", overflow, underflow); end
    step(1'b1, 8'h55, 1'b0, 2'd0);
    step(1'b0, 8'h00, 1'b1, 2'd0);
    n_vec++; if (rddata !== 8'h55) begin n_err++; $display("FAIL mid_after got %h want 55", rddata); end
    n_vec++; if (empty !== 1'b1)   begin n_err++; $display("FAIL mid_after_empty got %b want 1", empty); end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    srst = 1'b1; wr = 1'b0; wrdata = 8'h00; rd = 1'b0; shift = 2'd0;
    exp_rd = 8'h00;
    test_reset();
    test_fill();
    test_overflow_drain();
    test_skip();
    test_clamp();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
